// File: rtl/core_lsu_biu_pkg.sv
// Shared widths and BIU state encoding for the LSU bus interface unit.
package core_lsu_biu_pkg;
  localparam int CORE_XLEN            = 32;
  localparam int CORE_LSU_WMASK_WIDTH = CORE_XLEN / 8;

  typedef enum logic [1:0] {
    BIU_IDLE = 2'd0,
    BIU_REQ  = 2'd1,
    BIU_WAIT = 2'd2,
    BIU_RESP = 2'd3
  } biu_state_e;
endpackage

// File: rtl/core_biu_timeout_cnt.sv
// Saturating response-timeout counter: clear, count-enable, expire flag.
module core_biu_timeout_cnt #(
  parameter int CNT_W = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // LIMIT of zero disables the timeout entirely.
  assign expire = (LIMIT != 0) && (cnt_q == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/gnrl_dfflr.sv
// Generic load-enabled register with synchronous active-high reset to zero.
module gnrl_dfflr #(
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= '0;
    end else if (lden) begin
      qout <= dnxt;
    end
  end
endmodule

// File: rtl/core_lsu_biu.sv
// LSU-to-data-bus interface: one outstanding transaction, IDLE->REQ->WAIT->RESP,
// with a bounded wait for the bus response.
module core_lsu_biu
  import core_lsu_biu_pkg::*;
#(
  parameter int XLEN    = CORE_XLEN,
  parameter int WMASK_W = CORE_LSU_WMASK_WIDTH,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [XLEN-1:0]    lsu_req_addr,
  input  logic [XLEN-1:0]    lsu_req_wdata,
  input  logic [WMASK_W-1:0] lsu_req_wmask,
  input  logic               lsu_req_wen,
  output logic               lsu_rsp_valid,
  input  logic               lsu_rsp_ready,
  output logic [XLEN-1:0]    lsu_rsp_rdata,
  output logic               lsu_rsp_err,
  output logic               bus_req_valid,
  input  logic               bus_req_ready,
  output logic [XLEN-1:0]    bus_req_addr,
  output logic [XLEN-1:0]    bus_req_wdata,
  output logic [WMASK_W-1:0] bus_req_wmask,
  output logic               bus_req_wen,
  input  logic               bus_rsp_valid,
  input  logic [XLEN-1:0]    bus_rsp_rdata,
  input  logic               bus_rsp_err
);
  biu_state_e state_d, state_q;

  logic               ld_req;
  logic               ld_rsp;
  logic               cnt_clr;
  logic               cnt_en;
  logic               tmo_expire;
  logic [XLEN-1:0]    addr_d, addr_q;
  logic [WMASK_W-1:0] wmask_d, wmask_q;
  logic [XLEN-1:0]    wdata_q;
  logic               wen_q;
  logic [XLEN-1:0]    rdata_d, rdata_q;
  logic               err_d, err_q;

  assign addr_d  = lsu_req_addr & ~XLEN'(3);
  assign wmask_d = lsu_req_wen ? lsu_req_wmask : '0;

  always_comb begin
    state_d = state_q;
    ld_req  = 1'b0;
    ld_rsp  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      BIU_IDLE: begin
        if (lsu_req_valid) begin
          ld_req  = 1'b1;
          state_d = BIU_REQ;
        end
      end
      BIU_REQ: begin
        if (bus_req_ready) begin
          cnt_clr = 1'b1;
          state_d = BIU_WAIT;
        end
      end
      BIU_WAIT: begin
        cnt_en = 1'b1;
        // A response arriving on the expiry cycle still takes priority.
        if (bus_rsp_valid) begin
          ld_rsp  = 1'b1;
          rdata_d = wen_q ? '0 : bus_rsp_rdata;
          err_d   = bus_rsp_err;
          state_d = BIU_RESP;
        end else if (tmo_expire) begin
          ld_rsp  = 1'b1;
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = BIU_RESP;
        end
      end
      BIU_RESP: begin
        if (lsu_rsp_ready) begin
          state_d = BIU_IDLE;
        end
      end
      default: state_d = BIU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BIU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  gnrl_dfflr #(.DW(XLEN))    u_addr  (.clk(clk), .rst(rst), .lden(ld_req), .dnxt(addr_d),        .qout(addr_q));
  gnrl_dfflr #(.DW(XLEN))    u_wdata (.clk(clk), .rst(rst), .lden(ld_req), .dnxt(lsu_req_wdata), .qout(wdata_q));
  gnrl_dfflr #(.DW(WMASK_W)) u_wmask (.clk(clk), .rst(rst), .lden(ld_req), .dnxt(wmask_d),       .qout(wmask_q));
  gnrl_dfflr #(.DW(1))       u_wen   (.clk(clk), .rst(rst), .lden(ld_req), .dnxt(lsu_req_wen),   .qout(wen_q));
  gnrl_dfflr #(.DW(XLEN))    u_rdata (.clk(clk), .rst(rst), .lden(ld_rsp), .dnxt(rdata_d),       .qout(rdata_q));
  gnrl_dfflr #(.DW(1))       u_err   (.clk(clk), .rst(rst), .lden(ld_rsp), .dnxt(err_d),         .qout(err_q));

  core_biu_timeout_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expire (tmo_expire)
  );

  assign lsu_req_ready = (state_q == BIU_IDLE);
  assign lsu_rsp_valid = (state_q == BIU_RESP);
  assign lsu_rsp_rdata = rdata_q;
  assign lsu_rsp_err   = err_q;
  assign bus_req_valid = (state_q == BIU_REQ);
  assign bus_req_addr  = addr_q;
  assign bus_req_wdata = wdata_q;
  assign bus_req_wmask = wmask_q;
  assign bus_req_wen   = wen_q;
endmodule
